// File: rtl/mem_data_reg_pkg.sv
// mem_data_reg_pkg: shared widths, FSM encoding and access-type constants for the MDR sequencer
package mem_data_reg_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;
endpackage

// File: rtl/mdr_watchdog.sv
// mdr_watchdog: counts enabled cycles since clear and flags the last allowed cycle
module mdr_watchdog #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(LIMIT) + 1;
  logic [CW-1:0] cnt;
  assign expired = en && cnt == CW'(LIMIT - 1);
  // cycle counter, restarted by each accepted command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mem_data_reg.sv
// mem_data_reg: memory data register with req/ack read/write sequencer; MDR_TIMEOUT_EN adds an ack timeout
module mem_data_reg
  import mem_data_reg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              rd_start,
  input  logic              wr_start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_t state, state_nx;
  logic accept, timeout;
  assign accept = state == IDLE && (rd_start || wr_start);
  assign mem_req = state == ACCESS;
  assign busy = state != IDLE;
  assign done = state == DONE;
`ifdef MDR_TIMEOUT_EN
  mdr_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clk(CLK),
    .rst(Reset),
    .clr(accept),
    .en(state == ACCESS && !mem_ack),
    .expired(timeout)
  );
  // sticky timeout flag, cleared when the next command is accepted
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) err <= 1'b0;
    else if (accept) err <= 1'b0;
    else if (timeout) err <= 1'b1;
  end
`else
  logic unused_cfg;
  assign unused_cfg = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign err = 1'b0;
`endif
  // state register; reset drops mem_req immediately
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else state <= state_nx;
  end
  // next state: an ack (or timeout) ends the access, DONE lasts one cycle
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE   ? (accept ? ACCESS : IDLE) :
               state == ACCESS ? ((mem_ack || timeout) ? DONE : ACCESS) : IDLE;
  end
  // access parameters latched at accept and held until the next accept; write wins a tie
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= RD;
    end else if (accept) begin
      mem_addr <= addr;
      mem_wdata <= wr_data;
      mem_we <= wr_start ? WR : RD;
    end
  end
  // MDR loads only on a read ack inside ACCESS
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) mdr_out <= '0;
    else if (state == ACCESS && mem_ack && mem_we == RD) mdr_out <= mem_rdata;
  end
endmodule

// File: tb/tb_mem_data_reg.sv
// tb_mem_data_reg: directed self-checking bench for mem_data_reg
module tb_mem_data_reg;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_start = 1'b0, wr_start = 1'b0, mem_ack = 1'b0;
  logic [15:0] addr = '0, wr_data = '0, mem_rdata = '0;
  logic        mem_req, mem_we, busy, done, err;
  logic [15:0] mem_addr, mem_wdata, mdr_out;
  int passed = 0, total = 0;

  mem_data_reg dut (
    .CLK(clk), .Reset(rst), .rd_start(rd_start), .wr_start(wr_start),
    .addr(addr), .wr_data(wr_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mdr_out(mdr_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mdr", mdr_out, 0);
    chk("rst_err", err, 0);
    chk("rst_we", mem_we, 0);
    @(negedge clk);
    rst = 1'b0;
    // read, zero wait
    rd_start = 1'b1; addr = 16'h0040;
    tick;
    rd_start = 1'b0; addr = 16'h0000;
    chk("rd_req", mem_req, 1);
    chk("rd_we", mem_we, 0);
    chk("rd_addr", mem_addr, 16'h0040);
    chk("rd_busy", busy, 1);
    chk("rd_nodone", done, 0);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick;
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    chk("rd_done", done, 1);
    chk("rd_mdr", mdr_out, 16'hBEEF);
    chk("rd_req_off", mem_req, 0);
    chk("rd_busy_done", busy, 1);
    tick;
    chk("rd_done_off", done, 0);
    chk("rd_idle", busy, 0);
    // write, 3 wait cycles
    wr_start = 1'b1; addr = 16'h0010; wr_data = 16'h1234;
    tick;
    wr_start = 1'b0; addr = 16'hFFFF; wr_data = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      chk("wr_req", mem_req, 1);
      chk("wr_we", mem_we, 1);
      chk("wr_wdata", mem_wdata, 16'h1234);
      chk("wr_addr", mem_addr, 16'h0010);
      chk("wr_nodone", done, 0);
      tick;
    end
    chk("wr_req4", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick;
    mem_ack = 1'b0;
    chk("wr_done", done, 1);
    chk("wr_mdr", mdr_out, 16'hBEEF);
    tick;
    chk("wr_done_off", done, 0);
    // simultaneous commands: write wins; command during ACCESS ignored
    rd_start = 1'b1; wr_start = 1'b1; addr = 16'h0020; wr_data = 16'h5555;
    tick;
    wr_start = 1'b0; addr = 16'h0099; wr_data = 16'h0000;
    chk("both_we", mem_we, 1);
    chk("both_wdata", mem_wdata, 16'h5555);
    tick;
    rd_start = 1'b0;
    chk("busy_req", mem_req, 1);
    chk("busy_addr", mem_addr, 16'h0020);
    chk("busy_we", mem_we, 1);
    mem_ack = 1'b1; mem_rdata = 16'hAAAA;
    tick;
    mem_ack = 1'b0;
    chk("both_done", done, 1);
    chk("both_mdr", mdr_out, 16'hBEEF);
    tick;
    chk("both_done_off", done, 0);
    chk("both_idle", busy, 0);
    tick;
    chk("no_queued_req", mem_req, 0);
    chk("no_queued_busy", busy, 0);
    // stray ack in IDLE
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    tick;
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    chk("stray_busy", busy, 0);
    chk("stray_mdr", mdr_out, 16'hBEEF);
    chk("stray_done", done, 0);
    // reset mid-access
    rd_start = 1'b1; addr = 16'h0030;
    tick;
    rd_start = 1'b0;
    chk("mid_req", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_req_drop", mem_req, 0);
    chk("mid_mdr_clr", mdr_out, 0);
    chk("mid_busy", busy, 0);
    tick;
    rst = 1'b0;
    chk("mid_nodone", done, 0);
    tick;
    chk("mid_nodone2", done, 0);
    rd_start = 1'b1; addr = 16'h0050;
    tick;
    rd_start = 1'b0;
    chk("post_req", mem_req, 1);
    chk("post_addr", mem_addr, 16'h0050);
    mem_ack = 1'b1; mem_rdata = 16'hC0DE;
    tick;
    mem_ack = 1'b0;
    chk("post_done", done, 1);
    chk("post_mdr", mdr_out, 16'hC0DE);
    tick;
    chk("post_done_off", done, 0);
`ifdef MDR_TIMEOUT_EN
    // timeout: never ack
    rd_start = 1'b1; addr = 16'h0060;
    tick;
    rd_start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("to_req", mem_req, 1);
      tick;
    end
    chk("to_req_drop", mem_req, 0);
    chk("to_done", done, 1);
    chk("to_err", err, 1);
    chk("to_mdr", mdr_out, 16'hC0DE);
    tick;
    chk("to_done_off", done, 0);
    chk("to_err_sticky", err, 1);
    wr_start = 1'b1; addr = 16'h0070; wr_data = 16'h0001;
    tick;
    wr_start = 1'b0;
    chk("to_err_clr", err, 0);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    tick;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
